// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth multiplier, one recoded digit per cycle
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           digit
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] m_reg, q_reg;
  logic            prev;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   m_ext, pp_mag, pp, pp_shift;
  logic            accept, last_step;

  // Sign-magnitude digit code: bit 2 = negate, bit 1 = x2, bit 0 = x1
  function automatic logic [2:0] recode(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: return 3'b001;
      3'b011:         return 3'b010;
      3'b100:         return 3'b110;
      3'b101, 3'b110: return 3'b101;
      default:        return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    digit      = 3'b000;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          accept     = 1'b1;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        digit = recode({q_reg[1:0], prev});
        if (count == LAST) begin
          state_next = S_DONE;
          last_step  = 1'b1;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Partial product is built at full product width so +/-2M never overflows
  always_comb begin
    m_ext    = {{WIDTH{m_reg[WIDTH-1]}}, m_reg};
    pp_mag   = digit[1] ? (m_ext << 1) : (digit[0] ? m_ext : '0);
    pp       = digit[2] ? (-pp_mag) : pp_mag;
    pp_shift = pp << {count, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg   <= '0;
      q_reg   <= '0;
      prev    <= 1'b0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      m_reg <= multiplicand;
      q_reg <= multiplier;
      prev  <= 1'b0;
      acc   <= '0;
      count <= '0;
    end else if (busy) begin
      acc   <= acc + pp_shift;
      prev  <= q_reg[1];
      q_reg <= {{2{q_reg[WIDTH-1]}}, q_reg[WIDTH-1:2]};
      count <= count + CW'(1);
      if (last_step) product <= acc + pp_shift;
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - self-checking bench for booth_r4_seq_mult at WIDTH=8 and WIDTH=16
module tb_booth_r4_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_i [2];
  logic [15:0] mc_i [2];
  logic [15:0] mp_i [2];

  logic [15:0] product8;
  logic [31:0] product16;
  logic        busy8, done8, busy16, done16;
  logic [2:0]  digit8, digit16;

  logic [31:0] prod_o [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [2:0]  dig_o  [2];

  assign prod_o[0] = {16'h0000, product8};
  assign prod_o[1] = product16;
  assign busy_o[0] = busy8;
  assign busy_o[1] = busy16;
  assign done_o[0] = done8;
  assign done_o[1] = done16;
  assign dig_o[0]  = digit8;
  assign dig_o[1]  = digit16;

  booth_r4_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start_i[0]),
    .multiplicand(mc_i[0][7:0]), .multiplier(mp_i[0][7:0]),
    .product(product8), .busy(busy8), .done(done8), .digit(digit8)
  );

  booth_r4_seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start_i[1]),
    .multiplicand(mc_i[1]), .multiplier(mp_i[1]),
    .product(product16), .busy(busy16), .done(done16), .digit(digit16)
  );

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  function automatic int wd(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic longint sext(input logic [15:0] x, input int w);
    longint r;
    r = longint'(x) & ((longint'(1) << w) - 1);
    if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic logic [31:0] trunc(input longint p, input int w);
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int qbit(input longint q, input int n);
    if (n < 0) return 0;
    return int'((q >>> n) & 1);
  endfunction

  // Booth digit value -2*q[2i+1] + q[2i] + q[2i-1], expressed in the sign/x2/x1 code
  function automatic logic [2:0] exp_digit(input longint q, input int i);
    int v;
    v = -2 * qbit(q, 2*i + 1) + qbit(q, 2*i) + qbit(q, 2*i - 1);
    case (v)
      1:       return 3'b001;
      2:       return 3'b010;
      -1:      return 3'b101;
      -2:      return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (w=%0d) at %0t: got %h, expected %h", name, wd(k), $time, act, exp);
    end
  endtask

  // Cycle-level model: phase 0 idle, 1..W/2 digit cycles, W/2+1 result cycle
  int          ph [2];
  longint      lm [2];
  longint      lq [2];
  logic [31:0] eprod [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k]    <= 0;
        eprod[k] <= '0;
      end else if (ph[k] == 0) begin
        if (start_i[k]) begin
          lm[k] <= sext(mc_i[k], wd(k));
          lq[k] <= sext(mp_i[k], wd(k));
          ph[k] <= 1;
        end
      end else if (ph[k] == wd(k) / 2) begin
        eprod[k] <= trunc(lm[k] * lq[k], wd(k));
        ph[k]    <= ph[k] + 1;
      end else if (ph[k] > wd(k) / 2) begin
        ph[k] <= 0;
      end else begin
        ph[k] <= ph[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic eb, ed;
        eb = (ph[k] >= 1) && (ph[k] <= wd(k) / 2);
        ed = (ph[k] == wd(k) / 2 + 1);
        chk("busy", k, busy_o[k], eb);
        chk("done", k, done_o[k], ed);
        chk("digit", k, dig_o[k], eb ? exp_digit(lq[k], ph[k] - 1) : 3'b000);
        chk("product", k, prod_o[k], eprod[k]);
        chk("busy_and_done", k, busy_o[k] & done_o[k], 1'b0);
      end
    end
  end

  logic [2:0] dq [$];

  // Counts negedges until done is seen; digits are collected while busy
  task automatic wait_done(input int k, input logic drop_start, output int n);
    int got;
    got = -1;
    dq.delete();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (drop_start && i == 1) start_i[k] = 1'b0;
      if (done_o[k]) begin
        got = i;
        break;
      end
      if (busy_o[k]) dq.push_back(dig_o[k]);
    end
    n = got;
  endtask

  task automatic run_op(input int k, input logic [15:0] m, input logic [15:0] q, output logic [31:0] p);
    int n;
    mc_i[k] = m;
    mp_i[k] = q;
    start_i[k] = 1'b1;
    wait_done(k, 1'b1, n);
    chk("latency", k, 32'(n - 1), 32'(wd(k) / 2));
    p = prod_o[k];
    @(negedge clk);
  endtask

  task automatic chk_digits(input string name, input logic [2:0] e0, input logic [2:0] e1,
                            input logic [2:0] e2, input logic [2:0] e3);
    logic [2:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, 0, dq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk(name, 0, (i < dq.size()) ? dq[i] : 3'bxxx, e[i]);
  endtask

  logic [31:0] p;
  int          n;
  logic        saw_done;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0;
      mc_i[k]    = '0;
      mp_i[k]    = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_product", 0, prod_o[0], 32'h0);
    chk("reset_busy", 0, busy_o[0], 1'b0);
    chk("reset_done", 0, done_o[0], 1'b0);
    chk("reset_digit", 0, dig_o[0], 3'b000);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 16'h0003, 16'h0005, p);
    chk("p_3x5", 0, p, 32'h0000_000F);
    chk_digits("dig_3x5", 3'b001, 3'b001, 3'b000, 3'b000);

    run_op(0, 16'h00F9, 16'h0006, p);
    chk("p_m7x6", 0, p, 32'h0000_FFD6);
    chk_digits("dig_m7x6", 3'b110, 3'b010, 3'b000, 3'b000);

    run_op(0, 16'h0080, 16'h0080, p);
    chk("p_m128xm128", 0, p, 32'h0000_4000);
    run_op(0, 16'h007F, 16'h0080, p);
    chk("p_127xm128", 0, p, 32'h0000_C080);
    run_op(0, 16'h0000, 16'h00FF, p);
    chk("p_0xm1", 0, p, 32'h0000_0000);

    // start held high; operands change mid-operation and must not be re-sampled
    mc_i[0] = 16'h0003; mp_i[0] = 16'h0005; start_i[0] = 1'b1;
    @(negedge clk);
    mc_i[0] = 16'h00F9; mp_i[0] = 16'h0006;
    wait_done(0, 1'b0, n);
    chk("held_lat1", 0, 32'(n), 32'd4);
    chk("held_p1", 0, prod_o[0], 32'h0000_000F);
    wait_done(0, 1'b0, n);
    chk("held_gap", 0, 32'(n), 32'd6);
    chk("held_p2", 0, prod_o[0], 32'h0000_FFD6);
    for (int i = 0; i < 40; i++) begin
      mc_i[0] = 16'($urandom_range(0, 255));
      mp_i[0] = 16'($urandom_range(0, 255));
      @(negedge clk);
    end
    start_i[0] = 1'b0;
    repeat (8) @(negedge clk);

    // reset in the second digit cycle discards the operation
    run_op(0, 16'h0003, 16'h0005, p);
    chk("p_pre_rst", 0, p, 32'h0000_000F);
    mc_i[0] = 16'h00F9; mp_i[0] = 16'h0006; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 0, busy_o[0], 1'b0);
    chk("rst_done", 0, done_o[0], 1'b0);
    chk("rst_product", 0, prod_o[0], 32'h0);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_done = saw_done | done_o[0];
    end
    chk("rst_no_done", 0, saw_done, 1'b0);
    run_op(0, 16'h00F9, 16'h0006, p);
    chk("p_after_rst", 0, p, 32'h0000_FFD6);

    // edge operands then a random sweep; the compare process checks each product
    for (int a = 0; a < 6; a++) begin
      for (int b = 0; b < 6; b++) begin
        logic [15:0] ev [6];
        ev = '{16'h0080, 16'h0081, 16'h00FF, 16'h0000, 16'h0001, 16'h007F};
        run_op(0, ev[a], ev[b], p);
      end
    end
    for (int i = 0; i < 1500; i++)
      run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), p);

    run_op(1, 16'h8000, 16'h8000, p);
    chk("p16_min_sq", 1, p, 32'h4000_0000);
    run_op(1, 16'h7FFF, 16'h8000, p);
    chk("p16_max_min", 1, p, 32'hC000_8000);
    run_op(1, 16'h04D2, 16'hFDC9, p);
    chk("p16_1234xm567", 1, p, 32'hFFF5_52E2);
    for (int i = 0; i < 20; i++)
      run_op(1, 16'($urandom), 16'($urandom), p);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
